// File: rtl/hazard_stall_controller.sv
// Issue-stage RAW hazard detector: holds fetch and inserts bubbles
// while a source register is still owned by an in-flight instruction.
module hazard_stall_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  instr_valid,
    output logic                  pc_en,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  out_valid,
    output logic [15:0]           stall_count,
    output logic [15:0]           issue_count
);

    localparam logic [5:0] OP_LOAD  = 6'b001000;
    localparam logic [5:0] OP_ALU   = 6'b000111;
    localparam logic [5:0] OP_STORE = 6'b001001;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       is_load, is_alu, is_store;
    logic       use_rs, use_rt, has_dest;
    logic [4:0] dest;
    logic       match, hazard, issue;
    logic       unused_bits;

    logic             sb_v [DEPTH];
    logic [4:0]       sb_d [DEPTH];

    assign opcode = instr_in[31:26];
    assign rs     = instr_in[25:21];
    assign rt     = instr_in[20:16];
    assign rd     = instr_in[15:11];

    assign unused_bits = ^instr_in;

    assign is_load  = (opcode == OP_LOAD);
    assign is_alu   = (opcode == OP_ALU);
    assign is_store = (opcode == OP_STORE);

    always_comb begin
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        has_dest = 1'b0;
        dest     = 5'd0;
        unique case (1'b1)
            is_load: begin
                use_rs   = 1'b1;
                has_dest = 1'b1;
                dest     = rt;
            end
            is_alu: begin
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                has_dest = 1'b1;
                dest     = rd;
            end
            is_store: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Only pre-edge scoreboard contents are compared, so an
    // instruction can never collide with its own destination.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v[i] && ((use_rs && rs == sb_d[i]) ||
                            (use_rt && rt == sb_d[i])))
                match = 1'b1;
        end
    end

    assign hazard = en & instr_valid & match;
    assign issue  = en & instr_valid & ~match;
    assign stall  = hazard;
    assign pc_en  = en & ~hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_v[i] <= 1'b0;
                sb_d[i] <= 5'd0;
            end
            instr_out   <= '0;
            out_valid   <= 1'b0;
            stall_count <= 16'd0;
            issue_count <= 16'd0;
        end else begin
            // Shift every cycle so entries age out after DEPTH edges.
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_v[i] <= sb_v[i-1];
                sb_d[i] <= sb_d[i-1];
            end
            sb_v[0] <= issue & has_dest;
            sb_d[0] <= issue ? dest : 5'd0;

            instr_out <= issue ? instr_in : '0;
            out_valid <= issue;

            if (issue)
                issue_count <= issue_count + 16'd1;
            if (hazard && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (DEPTH=3).
module tb_hazard_stall_controller;

    localparam logic [5:0] LD  = 6'b001000;
    localparam logic [5:0] ALU = 6'b000111;
    localparam logic [5:0] ST  = 6'b001001;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        pc_en;
    logic        stall;
    logic [31:0] instr_out;
    logic        out_valid;
    logic [15:0] stall_count;
    logic [15:0] issue_count;

    int n_chk = 0;
    int n_err = 0;

    hazard_stall_controller #(.DATA_WIDTH(32), .DEPTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .pc_en       (pc_en),
        .stall       (stall),
        .instr_out   (instr_out),
        .out_valid   (out_valid),
        .stall_count (stall_count),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op,
        input logic [4:0] s, input logic [4:0] t,
        input logic [4:0] d, input logic [5:0] fn);
        return {op, s, t, d, 5'd0, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    // Present a word until accepted; count bubbles on the way.
    task automatic issue_word(input string tag, input logic [31:0] w,
                              input int exp_bub);
        int b;
        b = 0;
        en = 1'b1;
        instr_valid = 1'b1;
        instr_in = w;
        #1;
        while (!pc_en && b < 10) begin
            b++;
            tick();
            chk({tag, "_bubble_valid"}, 32'(out_valid), 32'd0);
        end
        chk({tag, "_bubbles"}, b, exp_bub);
        tick();
        chk({tag, "_out"}, instr_out, w);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    logic [31:0] prog [8];
    int          bub  [8];
    logic [31:0] mul_w;

    initial begin
        rst = 1'b0;
        en = 1'b1;
        instr_valid = 1'b1;
        instr_in = 32'hDEAD_BEEF;

        // Reset with enable and garbage applied
        repeat (2) tick();
        chk("rst_out", instr_out, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_scnt", 32'(stall_count), 32'd0);
        chk("rst_icnt", 32'(issue_count), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_out", instr_out, 32'hDEAD_BEEF);
        chk("rel_valid", 32'(out_valid), 32'd1);
        chk("rel_icnt", 32'(issue_count), 32'd1);

        // Hazard program
        do_reset(1);
        prog[0] = enc(LD, 15, 0, 0, 0);
        prog[1] = enc(LD, 15, 1, 0, 0);
        prog[2] = enc(LD, 15, 2, 0, 0);
        prog[3] = enc(LD, 15, 3, 0, 0);
        prog[4] = enc(ALU, 1, 0, 4, 6'h22);
        prog[5] = enc(ALU, 2, 3, 5, 6'h22);
        prog[6] = enc(ALU, 4, 5, 6, 6'h18);
        prog[7] = enc(ST, 15, 6, 0, 0);
        bub = '{0, 0, 0, 0, 1, 1, 3, 3};
        for (int i = 0; i < 8; i++)
            issue_word($sformatf("prog%0d", i), prog[i], bub[i]);
        chk("prog_scnt", 32'(stall_count), 32'd8);
        chk("prog_icnt", 32'(issue_count), 32'd8);

        // Independent load stream
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            instr_in = enc(LD, 20, 5'(i + 1), 0, 0);
            #1;
            chk($sformatf("ind%0d_pc_en", i), 32'(pc_en), 32'd1);
            tick();
            chk($sformatf("ind%0d_valid", i), 32'(out_valid), 32'd1);
        end
        chk("ind_scnt", 32'(stall_count), 32'd0);
        chk("ind_icnt", 32'(issue_count), 32'd8);

        // Drain while disabled
        do_reset(1);
        issue_word("drain_ld", enc(LD, 15, 7, 0, 0), 0);
        en = 1'b0;
        instr_in = enc(ALU, 7, 8, 9, 6'h22);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("dis%0d_pc_en", i), 32'(pc_en), 32'd0);
            tick();
            chk($sformatf("dis%0d_valid", i), 32'(out_valid), 32'd0);
        end
        en = 1'b1;
        #1;
        chk("drain_stall", 32'(stall), 32'd0);
        issue_word("drain_sub", enc(ALU, 7, 8, 9, 6'h22), 0);
        chk("drain_scnt", 32'(stall_count), 32'd0);

        // Reset while a dependent op is stalled
        do_reset(1);
        issue_word("rms_ld", enc(LD, 15, 4, 0, 0), 0);
        mul_w = enc(ALU, 4, 5, 6, 6'h18);
        instr_in = mul_w;
        #1;
        chk("rms_stall", 32'(stall), 32'd1);
        tick();
        chk("rms_stall2", 32'(stall), 32'd1);
        do_reset(1);
        #1;
        chk("rms_nostall", 32'(stall), 32'd0);
        chk("rms_pc_en", 32'(pc_en), 32'd1);
        chk("rms_scnt", 32'(stall_count), 32'd0);
        tick();
        chk("rms_out", instr_out, mul_w);
        chk("rms_valid", 32'(out_valid), 32'd1);

        // Saturation: self-dependent load, 1 issue + 3 bubbles per period
        do_reset(1);
        en = 1'b1;
        instr_valid = 1'b1;
        instr_in = enc(LD, 1, 1, 0, 0);
        repeat (4 * 21844) @(posedge clk);
        #1;
        chk("sat_pre", 32'(stall_count), 32'h0000_FFFC);
        repeat (4 * 2) @(posedge clk);
        #1;
        chk("sat_hold", 32'(stall_count), 32'h0000_FFFF);
        chk("sat_icnt", 32'(issue_count), 32'h0000_5556);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
